collision_scanner: RTL and testbench

- Sequential, parametrised successor to the four-corner sprite wall check.
- Each query walks probe points along all four edges of a SIZE x SIZE sprite through one shared, pipelined map lookup port.
- Returns a per-edge hit mask (top/right/bottom/left) so the movement FSM can block only the offending direction.
- Sits between the player/AI movement logic and the level map ROM; one scanner per moving sprite.

---
 rtl/collision_pkg.sv | 47 ++++
 rtl/collision_scanner_probe_gen.sv | 92 +++++++++
 rtl/collision_scanner.sv | 147 ++++++++++++++
 tb/tb_collision_scanner.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared types and helpers for the sprite edge collision scanner.
// Edge order doubles as scan order: top, right, bottom, left.
package collision_pkg;

    typedef enum logic [1:0] {
        EDGE_TOP    = 2'd0,
        EDGE_RIGHT  = 2'd1,
        EDGE_BOTTOM = 2'd2,
        EDGE_LEFT   = 2'd3
    } edge_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic  valid;
        edge_t side;
        logic  oob;
    } tag_t;

    localparam int HIT_TOP    = 3;
    localparam int HIT_RIGHT  = 2;
    localparam int HIT_BOTTOM = 1;
    localparam int HIT_LEFT   = 0;

    function automatic int probes_per_edge(input int size, input int step);
        return size / step + 1;
    endfunction

    function automatic logic [3:0] hit_bit(input edge_t side);
        logic [3:0] m;
        m = '0;
        case (side)
            EDGE_TOP:    m[HIT_TOP]    = 1'b1;
            EDGE_RIGHT:  m[HIT_RIGHT]  = 1'b1;
            EDGE_BOTTOM: m[HIT_BOTTOM] = 1'b1;
            EDGE_LEFT:   m[HIT_LEFT]   = 1'b1;
            default:     m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/collision_scanner_probe_gen.sv
// Walks the probe points of all four sprite edges, one per advance strobe,
// and flags probes that fall outside the visible screen.
module probe_gen
    import collision_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int SIZE     = 32,
    parameter int STEP     = 8,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               advance,
    input  logic [COORD_W-1:0] base_x,
    input  logic [COORD_W-1:0] base_y,
    output logic [COORD_W-1:0] probe_x,
    output logic [COORD_W-1:0] probe_y,
    output edge_t              side,
    output logic               oob,
    output logic               last
);

    localparam int P       = probes_per_edge(SIZE, STEP);
    localparam int K_W     = $clog2(P);
    localparam int S_W     = COORD_W + 1;
    localparam int STEP_SH = $clog2(STEP);
    localparam logic [K_W-1:0] K_MAX = K_W'(P - 1);

    // remaining probes on the current edge; zero selects the SIZE-1 corner probe
    logic [K_W-1:0] k_rem_q;
    edge_t          side_q;
    logic [K_W-1:0] idx;
    logic [S_W-1:0] off, ext_x, ext_y, sum_x, sum_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_rem_q <= K_MAX;
            side_q  <= EDGE_TOP;
        end else if (load) begin
            k_rem_q <= K_MAX;
            side_q  <= EDGE_TOP;
        end else if (advance) begin
            if (k_rem_q == '0) begin
                k_rem_q <= K_MAX;
                side_q  <= edge_t'(side_q + 2'd1);
            end else begin
                k_rem_q <= k_rem_q - 1'b1;
            end
        end
    end

    always_comb begin
        idx   = K_MAX - k_rem_q;
        off   = (k_rem_q == '0) ? S_W'(SIZE - 1) : (S_W'(idx) << STEP_SH);
        ext_x = {1'b0, base_x};
        ext_y = {1'b0, base_y};
        sum_x = ext_x;
        sum_y = ext_y;
        case (side_q)
            EDGE_TOP: begin
                sum_x = ext_x + off;
                sum_y = ext_y;
            end
            EDGE_RIGHT: begin
                sum_x = ext_x + S_W'(SIZE - 1);
                sum_y = ext_y + off;
            end
            EDGE_BOTTOM: begin
                sum_x = ext_x + off;
                sum_y = ext_y + S_W'(SIZE - 1);
            end
            EDGE_LEFT: begin
                sum_x = ext_x;
                sum_y = ext_y + off;
            end
            default: begin
                sum_x = ext_x;
                sum_y = ext_y;
            end
        endcase
    end

    assign probe_x = sum_x[COORD_W-1:0];
    assign probe_y = sum_y[COORD_W-1:0];
    assign side    = side_q;
    assign oob     = sum_x[COORD_W] || sum_y[COORD_W] ||
                     (sum_x >= S_W'(SCREEN_W)) || (sum_y >= S_W'(SCREEN_H));
    assign last    = (side_q == EDGE_LEFT) && (k_rem_q == '0);

endmodule

// File: rtl/collision_scanner.sv
// Per-sprite edge collision scanner: issues edge probes to a pipelined map
// port and accumulates a per-edge hit mask for the movement FSM.
//
//   state | meaning
//   IDLE  | waiting for start
//   ISSUE | one probe per cycle; leaves after last probe or early-exit hit
//   DRAIN | waiting for in-flight lookups to return
//   DONE  | one-cycle done pulse, results final
module collision_scanner
    import collision_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int LEVEL_W  = 2,
    parameter int SIZE     = 32,
    parameter int STEP     = 8,
    parameter int MAP_LAT  = 1,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               early_exit,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [LEVEL_W-1:0] level_id,
    output logic               map_req,
    output logic [COORD_W-1:0] map_x,
    output logic [COORD_W-1:0] map_y,
    output logic [LEVEL_W-1:0] map_level,
    input  logic               map_wall,
    output logic               busy,
    output logic               done,
    output logic [3:0]         hit_mask,
    output logic               is_wall
);

    state_t             state_q, state_d;
    logic               armed_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic [LEVEL_W-1:0] level_q;
    logic               early_q;
    logic [3:0]         hit_mask_q;
    tag_t               tag_q [MAP_LAT];

    logic               accept, issuing, pipe_busy;
    logic [3:0]         ret_hits;
    logic [COORD_W-1:0] probe_x, probe_y;
    edge_t              probe_side;
    logic               probe_oob, probe_last;

    // armed_q blocks a start seen on the very first edge after reset release
    assign accept = (state_q == IDLE) && start && armed_q;

    probe_gen #(
        .COORD_W  (COORD_W),
        .SIZE     (SIZE),
        .STEP     (STEP),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_probe_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .advance (issuing),
        .base_x  (x_q),
        .base_y  (y_q),
        .probe_x (probe_x),
        .probe_y (probe_y),
        .side    (probe_side),
        .oob     (probe_oob),
        .last    (probe_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = ISSUE;
            ISSUE: if (probe_last || (early_q && ((hit_mask_q | ret_hits) != 4'd0)))
                       state_d = DRAIN;
            DRAIN: if (!pipe_busy) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issuing = (state_q == ISSUE);
        busy    = (state_q == ISSUE) || (state_q == DRAIN);
        done    = (state_q == DONE);
        map_req = issuing && !probe_oob;
        map_x   = issuing ? probe_x : '0;
        map_y   = issuing ? probe_y : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            level_q <= '0;
            early_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (accept) begin
                x_q     <= x;
                y_q     <= y;
                level_q <= level_id;
                early_q <= early_exit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAP_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{valid: issuing, side: probe_side, oob: probe_oob};
            for (int i = 1; i < MAP_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // the last stage lines up with map_wall; earlier stages are still in flight
    always_comb begin
        ret_hits = '0;
        if (tag_q[MAP_LAT-1].valid && (map_wall || tag_q[MAP_LAT-1].oob))
            ret_hits = hit_bit(tag_q[MAP_LAT-1].side);
        pipe_busy = 1'b0;
        for (int i = 0; i < MAP_LAT - 1; i++) pipe_busy = pipe_busy | tag_q[i].valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      hit_mask_q <= '0;
        else if (accept) hit_mask_q <= '0;
        else             hit_mask_q <= hit_mask_q | ret_hits;
    end

    assign hit_mask  = hit_mask_q;
    assign is_wall   = |hit_mask_q;
    assign map_level = level_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Randomized scoreboard bench for collision_scanner with a behavioural map
// ROM and a probe-list reference model.
module tb_collision_scanner;

    localparam int CW  = 10;
    localparam int LW  = 2;
    localparam int SZ  = 32;
    localparam int ST  = 8;
    localparam int LAT = 3;
    localparam int SW  = 640;
    localparam int SH  = 480;
    localparam int P   = SZ / ST + 1;
    localparam int NPR = 4 * P;

    typedef struct { int x; int y; int lvl; } req_t;
    typedef struct { int mask; int lat; int s; } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          early_exit = 1'b0;
    logic [CW-1:0] x = '0;
    logic [CW-1:0] y = '0;
    logic [LW-1:0] level_id = '0;
    logic          map_wall = 1'b0;
    logic          map_req, busy, done, is_wall;
    logic [CW-1:0] map_x, map_y;
    logic [LW-1:0] map_level;
    logic [3:0]    hit_mask;

    collision_scanner #(
        .COORD_W (CW), .LEVEL_W (LW), .SIZE (SZ), .STEP (ST),
        .MAP_LAT (LAT), .SCREEN_W (SW), .SCREEN_H (SH)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .early_exit (early_exit),
        .x (x), .y (y), .level_id (level_id),
        .map_req (map_req), .map_x (map_x), .map_y (map_y), .map_level (map_level),
        .map_wall (map_wall), .busy (busy), .done (done),
        .hit_mask (hit_mask), .is_wall (is_wall)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   dones = 0;
    int   map_mode = 0;
    int   pt_x = 0;
    int   pt_y = 0;
    req_t req_q[$];
    res_t res_q[$];
    bit   rom_pipe [0:LAT];
    req_t mon_req;
    res_t mon_res;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit map_fn(input int mode, input int lvl, input int px, input int py);
        case (mode)
            1:       return px == 131;
            2:       return ((px * 7 + py * 3 + lvl * 5) % 13) == 0;
            3:       return (px == pt_x) && (py == pt_y);
            default: return 1'b0;
        endcase
    endfunction

    // map ROM: answers each cycle's request LAT cycles later, junk when idle
    always @(negedge clk) begin
        for (int i = LAT; i > 0; i--) rom_pipe[i] = rom_pipe[i-1];
        rom_pipe[0] = map_req ? map_fn(map_mode, int'(map_level), int'(map_x), int'(map_y))
                              : 1'($urandom);
        map_wall = rom_pipe[LAT];
    end

    // reference: enumerate probes, apply early-exit cut-off, push expected requests
    task automatic build_expect(input int qx, input int qy, input int lvl, input bit early,
                                output int mask, output int lat);
        int px[NPR], py[NPR];
        bit oob[NPR], hit[NPR];
        int first, lastp, e, k, off;
        req_t r;
        first = -1;
        for (int i = 0; i < NPR; i++) begin
            e   = i / P;
            k   = i % P;
            off = (k == P - 1) ? SZ - 1 : k * ST;
            case (e)
                0:       begin px[i] = qx + off;    py[i] = qy;          end
                1:       begin px[i] = qx + SZ - 1; py[i] = qy + off;    end
                2:       begin px[i] = qx + off;    py[i] = qy + SZ - 1; end
                default: begin px[i] = qx;          py[i] = qy + off;    end
            endcase
            oob[i] = (px[i] >= SW) || (py[i] >= SH);
            hit[i] = oob[i] || map_fn(map_mode, lvl, px[i], py[i]);
            if (hit[i] && first < 0) first = i;
        end
        lastp = NPR - 1;
        if (early && first >= 0 && first + LAT < NPR - 1) lastp = first + LAT;
        mask = 0;
        for (int i = 0; i <= lastp; i++) begin
            if (!oob[i]) begin
                r.x = px[i]; r.y = py[i]; r.lvl = lvl;
                req_q.push_back(r);
            end
            if (hit[i]) mask = mask | (1 << (3 - i / P));
        end
        lat = lastp + 2 + LAT;
    endtask

    task automatic run_query(input int qx, input int qy, input int lvl, input bit early, input bit poke);
        int   mask, lat, d0, t, s;
        res_t r;
        build_expect(qx, qy, lvl, early, mask, lat);
        @(negedge clk);
        x = CW'(qx); y = CW'(qy); level_id = LW'(lvl); early_exit = early; start = 1'b1;
        s = cyc; d0 = dones;
        r.mask = mask; r.lat = lat; r.s = s;
        res_q.push_back(r);
        @(negedge clk);
        start = 1'b0;
        early_exit = 1'($urandom);
        x = CW'($urandom); y = CW'($urandom);
        t = 0;
        while (dones == d0 && t < 400) begin
            @(negedge clk);
            t++;
            start = poke && (((cyc - s) == 5) || ((cyc - s) == lat));
        end
        if (dones == d0) begin
            check("done_timeout", 32'(dones - d0), 32'd1);
            req_q.delete();
            res_q.delete();
        end
        @(negedge clk);
        start = 1'b0;
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_req"}, 32'(map_req), 32'd0);
        check({tag, "_mask"}, 32'(hit_mask), 32'd0);
        check({tag, "_is_wall"}, 32'(is_wall), 32'd0);
        check({tag, "_map_xyl"}, 32'({map_x, map_y, map_level}), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (map_req) begin
                check("req_expected", 32'(req_q.size() > 0), 32'd1);
                if (req_q.size() > 0) begin
                    mon_req = req_q.pop_front();
                    check("req_xyl", 32'({map_x, map_y, map_level}),
                          32'({CW'(mon_req.x), CW'(mon_req.y), LW'(mon_req.lvl)}));
                end
            end
            if (done) begin
                dones++;
                check("done_expected", 32'(res_q.size() > 0), 32'd1);
                if (res_q.size() > 0) begin
                    mon_res = res_q.pop_front();
                    check("hit_mask", 32'(hit_mask), 32'(mon_res.mask));
                    check("is_wall", 32'(is_wall), 32'(mon_res.mask != 0));
                    check("latency", 32'(cyc - mon_res.s), 32'(mon_res.lat));
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("reqs_outstanding", 32'(req_q.size()), 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int qx, qy, mask, lat;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        map_mode = 0; run_query(100, 100, 1, 1'b0, 1'b0);
        map_mode = 1; run_query(100, 100, 2, 1'b0, 1'b0);
        map_mode = 0; run_query(620, 0, 0, 1'b0, 1'b0);
        map_mode = 3; pt_x = 200; pt_y = 150; run_query(200, 150, 3, 1'b1, 1'b0);
        map_mode = 0; run_query(300, 200, 1, 1'b1, 1'b0);
        map_mode = 2; run_query(50, 60, 2, 1'b0, 1'b1);

        for (int n = 0; n < 14; n++) begin
            map_mode = $urandom_range(0, 2);
            qx = ($urandom_range(0, 3) == 0) ? $urandom_range(560, 1023) : $urandom_range(0, 560);
            qy = ($urandom_range(0, 3) == 0) ? $urandom_range(420, 1023) : $urandom_range(0, 420);
            run_query(qx, qy, $urandom_range(0, 3), 1'($urandom), 1'(n % 5 == 0));
        end

        // abort a query with reset, then try to start on the release edge
        map_mode = 2;
        build_expect(40, 40, 1, 1'b0, mask, lat);
        @(negedge clk);
        x = CW'(40); y = CW'(40); level_id = LW'(1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        req_q.delete();
        res_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1; start = 1'b1; x = CW'(64); y = CW'(64);
        @(negedge clk);
        start = 1'b0;
        check("start_at_release", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        check("still_idle", 32'(busy), 32'd0);
        run_query(64, 96, 2, 1'b0, 1'b0);
        map_mode = 1; run_query(110, 300, 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
